// File: rtl/bmd_latency_pkg.sv
// Shared widths and helpers for the BMD round-trip latency tracker.
package bmd_latency_pkg;

    localparam int CNT_W_DEF = 38;
    localparam int TAG_W_DEF = 6;
    localparam int SUM_W_DEF = 56;
    localparam int NUM_W_DEF = 32;

    // Widest accumulator the helper supports; callers cast in and out.
    localparam int SAT_W = 64;

    // Add two values and clamp at the all-ones value of a w-bit field.
    function automatic logic [SAT_W-1:0] sat_add(
        input logic [SAT_W-1:0] a,
        input logic [SAT_W-1:0] b,
        input int               w
    );
        logic [SAT_W:0] one;
        logic [SAT_W:0] lim;
        logic [SAT_W:0] s;
        one    = '0;
        one[0] = 1'b1;
        lim    = (one << w) - one;
        s      = {1'b0, a} + {1'b0, b};
        if (s > lim) begin
            s = lim;
        end
        return s[SAT_W-1:0];
    endfunction

endpackage

// File: rtl/bmd_latency_sdp_ram.sv
// Simple dual-port RAM, single clock, read-first, two registered read stages.
module bmd_latency_sdp_ram #(
    parameter int ADDR_W = 6,
    parameter int DATA_W = 38
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] rd_stage_q;
    logic [DATA_W-1:0] rd_stage_d;
    logic [DATA_W-1:0] rdata_q;
    logic [DATA_W-1:0] rdata_d;

    // The array read happens in the same cycle as a colliding write, so the
    // old contents are captured (read-first).
    always_comb begin
        rd_stage_d = rd_stage_q;
        if (re) begin
            rd_stage_d = mem[raddr];
        end
        rdata_d = rd_stage_q;
    end

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        rd_stage_q <= rd_stage_d;
        rdata_q    <= rdata_d;
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/bmd_latency_tracker.sv
// Per-tag round-trip latency tracker: stamps requests by tag, measures the
// completion latency and keeps min/max/sum/count statistics and error flags.
module bmd_latency_tracker
    import bmd_latency_pkg::*;
#(
    parameter int CNT_W         = CNT_W_DEF,
    parameter int TAG_W         = TAG_W_DEF,
    parameter int SUM_W         = SUM_W_DEF,
    parameter int NUM_W         = NUM_W_DEF,
    parameter int SAMPLE_TARGET = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [CNT_W-1:0] lat_cnt,
    input  logic             stats_clr,
    input  logic             stamp_vld,
    input  logic [TAG_W-1:0] stamp_tag,
    input  logic             cpl_vld,
    input  logic [TAG_W-1:0] cpl_tag,
    output logic             lat_vld,
    output logic [CNT_W-1:0] lat_data,
    output logic [CNT_W-1:0] lat_min,
    output logic [CNT_W-1:0] lat_max,
    output logic [SUM_W-1:0] lat_sum,
    output logic [NUM_W-1:0] lat_num,
    output logic             done,
    output logic             err_dup,
    output logic             err_orphan,
    output logic [TAG_W:0]   outstanding
);

    localparam int DEPTH = 1 << TAG_W;

    logic [DEPTH-1:0] valid_q, valid_d;
    logic [TAG_W:0]   outstanding_q, outstanding_d;
    logic             err_dup_q, err_dup_d;
    logic             err_orphan_q, err_orphan_d;
    logic             p1_vld_q, p1_vld_d;
    logic [CNT_W-1:0] p1_cnt_q, p1_cnt_d;
    logic             p2_vld_q, p2_vld_d;
    logic [CNT_W-1:0] p2_cnt_q, p2_cnt_d;
    logic             lat_vld_q, lat_vld_d;
    logic [CNT_W-1:0] lat_data_q, lat_data_d;
    logic [CNT_W-1:0] lat_min_q, lat_min_d;
    logic [CNT_W-1:0] lat_max_q, lat_max_d;
    logic [SUM_W-1:0] lat_sum_q, lat_sum_d;
    logic [NUM_W-1:0] lat_num_q, lat_num_d;
    logic             done_q, done_d;

    logic             clr_now;
    logic             cpl_hit;
    logic             same_tag;
    logic             stamp_inc;
    logic             ram_we;
    logic [CNT_W-1:0] ram_rdata;

    assign clr_now = rst | stats_clr;

    bmd_latency_sdp_ram #(
        .ADDR_W (TAG_W),
        .DATA_W (CNT_W)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .waddr (stamp_tag),
        .wdata (lat_cnt),
        .re    (cpl_hit),
        .raddr (cpl_tag),
        .rdata (ram_rdata)
    );

    always_comb begin
        cpl_hit   = cpl_vld & valid_q[cpl_tag] & ~clr_now;
        // A stamp landing on the tag that completes this cycle restarts it
        // rather than duplicating it, so the count stays consistent.
        same_tag  = stamp_vld & cpl_hit & (stamp_tag == cpl_tag);
        stamp_inc = stamp_vld & (~valid_q[stamp_tag] | same_tag);
        ram_we    = stamp_vld & ~clr_now;

        valid_d       = valid_q;
        outstanding_d = outstanding_q;
        err_dup_d     = err_dup_q;
        err_orphan_d  = err_orphan_q;
        p1_vld_d      = cpl_hit;
        p1_cnt_d      = lat_cnt;
        p2_vld_d      = p1_vld_q;
        p2_cnt_d      = p1_cnt_q;
        lat_vld_d     = p2_vld_q;
        lat_data_d    = lat_data_q;
        lat_min_d     = lat_min_q;
        lat_max_d     = lat_max_q;
        lat_sum_d     = lat_sum_q;
        lat_num_d     = lat_num_q;
        done_d        = done_q;

        if (cpl_hit) begin
            valid_d[cpl_tag] = 1'b0;
        end
        if (cpl_vld && !valid_q[cpl_tag]) begin
            err_orphan_d = 1'b1;
        end
        if (stamp_vld) begin
            valid_d[stamp_tag] = 1'b1;
            if (valid_q[stamp_tag] && !same_tag) begin
                err_dup_d = 1'b1;
            end
        end
        outstanding_d = outstanding_q + {{TAG_W{1'b0}}, stamp_inc}
                                      - {{TAG_W{1'b0}}, cpl_hit};

        // Modular subtraction absorbs a counter wrap between stamp and completion.
        if (p2_vld_q) begin
            lat_data_d = p2_cnt_q - ram_rdata;
        end

        if (lat_vld_q && !done_q) begin
            lat_num_d = NUM_W'(sat_add(SAT_W'(lat_num_q), SAT_W'(1), NUM_W));
            lat_sum_d = SUM_W'(sat_add(SAT_W'(lat_sum_q), SAT_W'(lat_data_q), SUM_W));
            if (lat_data_q < lat_min_q) begin
                lat_min_d = lat_data_q;
            end
            if (lat_data_q > lat_max_q) begin
                lat_max_d = lat_data_q;
            end
            done_d = (SAMPLE_TARGET != 0) && (lat_num_d == NUM_W'(SAMPLE_TARGET));
        end

        if (stats_clr) begin
            valid_d       = '0;
            outstanding_d = '0;
            err_dup_d     = 1'b0;
            err_orphan_d  = 1'b0;
            p1_vld_d      = 1'b0;
            p2_vld_d      = 1'b0;
            lat_vld_d     = 1'b0;
            lat_data_d    = '0;
            lat_min_d     = '1;
            lat_max_d     = '0;
            lat_sum_d     = '0;
            lat_num_d     = '0;
            done_d        = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q       <= '0;
            outstanding_q <= '0;
            err_dup_q     <= 1'b0;
            err_orphan_q  <= 1'b0;
            p1_vld_q      <= 1'b0;
            p1_cnt_q      <= '0;
            p2_vld_q      <= 1'b0;
            p2_cnt_q      <= '0;
            lat_vld_q     <= 1'b0;
            lat_data_q    <= '0;
            lat_min_q     <= '1;
            lat_max_q     <= '0;
            lat_sum_q     <= '0;
            lat_num_q     <= '0;
            done_q        <= 1'b0;
        end else begin
            valid_q       <= valid_d;
            outstanding_q <= outstanding_d;
            err_dup_q     <= err_dup_d;
            err_orphan_q  <= err_orphan_d;
            p1_vld_q      <= p1_vld_d;
            p1_cnt_q      <= p1_cnt_d;
            p2_vld_q      <= p2_vld_d;
            p2_cnt_q      <= p2_cnt_d;
            lat_vld_q     <= lat_vld_d;
            lat_data_q    <= lat_data_d;
            lat_min_q     <= lat_min_d;
            lat_max_q     <= lat_max_d;
            lat_sum_q     <= lat_sum_d;
            lat_num_q     <= lat_num_d;
            done_q        <= done_d;
        end
    end

    assign lat_vld     = lat_vld_q;
    assign lat_data    = lat_data_q;
    assign lat_min     = lat_min_q;
    assign lat_max     = lat_max_q;
    assign lat_sum     = lat_sum_q;
    assign lat_num     = lat_num_q;
    assign done        = done_q;
    assign err_dup     = err_dup_q;
    assign err_orphan  = err_orphan_q;
    assign outstanding = outstanding_q;

endmodule

// File: tb/tb_bmd_latency_tracker.sv
// Bench for bmd_latency_tracker: two instances (free-running and a 4-sample
// target) share stimulus; a tag-level model predicts latencies and statistics.
module tb_bmd_latency_tracker;

    localparam int CNT_W = 38;
    localparam int TAG_W = 6;
    localparam int SUM_W = 56;
    localparam int NUM_W = 32;
    localparam logic [63:0] MAXC = (64'd1 << CNT_W) - 64'd1;

    logic             clk = 1'b0;
    logic             rst;
    logic [CNT_W-1:0] lat_cnt;
    logic             stats_clr;
    logic             stamp_vld;
    logic [TAG_W-1:0] stamp_tag;
    logic             cpl_vld;
    logic [TAG_W-1:0] cpl_tag;

    logic             a_lat_vld, b_lat_vld;
    logic [CNT_W-1:0] a_lat_data, b_lat_data;
    logic [CNT_W-1:0] a_lat_min, b_lat_min;
    logic [CNT_W-1:0] a_lat_max, b_lat_max;
    logic [SUM_W-1:0] a_lat_sum, b_lat_sum;
    logic [NUM_W-1:0] a_lat_num, b_lat_num;
    logic             a_done, b_done;
    logic             a_err_dup, b_err_dup;
    logic             a_err_orphan, b_err_orphan;
    logic [TAG_W:0]   a_outstanding, b_outstanding;

    always #2 clk = ~clk;

    bmd_latency_tracker #(.SAMPLE_TARGET(0)) dut_a (
        .clk(clk), .rst(rst), .lat_cnt(lat_cnt), .stats_clr(stats_clr),
        .stamp_vld(stamp_vld), .stamp_tag(stamp_tag), .cpl_vld(cpl_vld), .cpl_tag(cpl_tag),
        .lat_vld(a_lat_vld), .lat_data(a_lat_data), .lat_min(a_lat_min), .lat_max(a_lat_max),
        .lat_sum(a_lat_sum), .lat_num(a_lat_num), .done(a_done), .err_dup(a_err_dup),
        .err_orphan(a_err_orphan), .outstanding(a_outstanding)
    );

    bmd_latency_tracker #(.SAMPLE_TARGET(4)) dut_b (
        .clk(clk), .rst(rst), .lat_cnt(lat_cnt), .stats_clr(stats_clr),
        .stamp_vld(stamp_vld), .stamp_tag(stamp_tag), .cpl_vld(cpl_vld), .cpl_tag(cpl_tag),
        .lat_vld(b_lat_vld), .lat_data(b_lat_data), .lat_min(b_lat_min), .lat_max(b_lat_max),
        .lat_sum(b_lat_sum), .lat_num(b_lat_num), .done(b_done), .err_dup(b_err_dup),
        .err_orphan(b_err_orphan), .outstanding(b_outstanding)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    logic [CNT_W-1:0] cnt_r;

    // Scoreboard: expected latency and the step it was issued in.
    logic [CNT_W-1:0] exp_q[$];
    int               exp_cyc_q[$];

    // Reference model: which tags are outstanding and their stamp values.
    bit [63:0]        mv;
    logic [CNT_W-1:0] mstamp [64];
    bit               m_dup, m_orph;
    longint           m_min [2];
    longint           m_max [2];
    longint           m_sum [2];
    longint           m_num [2];
    bit               m_done [2];
    int               m_target [2];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    task automatic model_clear();
        mv     = '0;
        m_dup  = 1'b0;
        m_orph = 1'b0;
        for (int k = 0; k < 2; k++) begin
            m_min[k]  = longint'(MAXC);
            m_max[k]  = 0;
            m_sum[k]  = 0;
            m_num[k]  = 0;
            m_done[k] = 1'b0;
        end
    endtask

    task automatic model_sample(input logic [CNT_W-1:0] lat);
        for (int k = 0; k < 2; k++) begin
            if (!m_done[k]) begin
                m_num[k]++;
                m_sum[k] = m_sum[k] + longint'(lat);
                if (longint'(lat) < m_min[k]) m_min[k] = longint'(lat);
                if (longint'(lat) > m_max[k]) m_max[k] = longint'(lat);
                if (m_target[k] != 0 && m_num[k] == longint'(m_target[k])) m_done[k] = 1'b1;
            end
        end
    endtask

    // One clock of stimulus; the model is advanced with the same inputs.
    task automatic step(input bit sv, input int st, input bit cv, input int ct, input bit clr);
        logic [CNT_W-1:0] lat;
        bit hit;
        stamp_vld = sv;
        stamp_tag = TAG_W'(st);
        cpl_vld   = cv;
        cpl_tag   = TAG_W'(ct);
        stats_clr = clr;
        lat_cnt   = cnt_r;
        if (clr) begin
            model_clear();
            while (exp_cyc_q.size() > 0 && exp_cyc_q[$] >= cyc - 2) begin
                void'(exp_q.pop_back());
                void'(exp_cyc_q.pop_back());
            end
        end else begin
            hit = cv && mv[ct];
            if (cv && !mv[ct]) m_orph = 1'b1;
            if (hit) begin
                lat = cnt_r - mstamp[ct];
                exp_q.push_back(lat);
                exp_cyc_q.push_back(cyc);
                model_sample(lat);
                mv[ct] = 1'b0;
            end
            if (sv) begin
                if (mv[st]) m_dup = 1'b1;
                mv[st]     = 1'b1;
                mstamp[st] = cnt_r;
            end
        end
        @(posedge clk);
        #1;
        cyc++;
        cnt_r = cnt_r + 1'b1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0);
    endtask

    task automatic check_state(input string tagname);
        check({tagname, "_min"},  64'(a_lat_min), 64'(m_min[0]));
        check({tagname, "_max"},  64'(a_lat_max), 64'(m_max[0]));
        check({tagname, "_sum"},  64'(a_lat_sum), 64'(m_sum[0]));
        check({tagname, "_num"},  64'(a_lat_num), 64'(m_num[0]));
        check({tagname, "_done"}, 64'(a_done),    64'(m_done[0]));
        check({tagname, "_min_t4"},  64'(b_lat_min), 64'(m_min[1]));
        check({tagname, "_max_t4"},  64'(b_lat_max), 64'(m_max[1]));
        check({tagname, "_sum_t4"},  64'(b_lat_sum), 64'(m_sum[1]));
        check({tagname, "_num_t4"},  64'(b_lat_num), 64'(m_num[1]));
        check({tagname, "_done_t4"}, 64'(b_done),    64'(m_done[1]));
        check({tagname, "_err_dup"},    64'(a_err_dup),    64'(m_dup));
        check({tagname, "_err_orphan"}, 64'(a_err_orphan), 64'(m_orph));
        check({tagname, "_outstanding"}, 64'(a_outstanding), 64'($countones(mv)));
        check({tagname, "_outstanding_t4"}, 64'(b_outstanding), 64'($countones(mv)));
    endtask

    // Monitor: every strobe must match the oldest expectation, 3 cycles late.
    always @(negedge clk) begin
        logic [CNT_W-1:0] e;
        int ec;
        if (!rst && (a_lat_vld || b_lat_vld)) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_strobe: got lat_data %0h expected no strobe", a_lat_data);
            end else begin
                e  = exp_q.pop_front();
                ec = exp_cyc_q.pop_front();
                check("lat_data", 64'(a_lat_data), 64'(e));
                check("lat_data_t4", 64'(b_lat_data), 64'(e));
                check("lat_vld_both", {62'd0, a_lat_vld, b_lat_vld}, 64'd3);
                check("strobe_cycle", 64'(cyc), 64'(ec + 3));
            end
        end
    end

    initial begin
        m_target[0] = 0;
        m_target[1] = 4;
        model_clear();
        rst = 1'b1;
        stats_clr = 1'b0;
        stamp_vld = 1'b0;
        stamp_tag = '0;
        cpl_vld = 1'b0;
        cpl_tag = '0;
        cnt_r = '0;
        lat_cnt = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset state
        check("rst_lat_vld", 64'(a_lat_vld), 64'd0);
        check("rst_lat_data", 64'(a_lat_data), 64'd0);
        check("rst_lat_min", 64'(a_lat_min), MAXC);
        check_state("rst");

        // Single tag
        cnt_r = 38'd100;
        step(1, 5, 0, 0, 0);
        idle(2);
        cnt_r = 38'd340;
        step(0, 0, 1, 5, 0);
        idle(5);
        check("single_lat", 64'(a_lat_data), 64'd240);
        check("single_sum", 64'(a_lat_sum), 64'd240);
        check_state("single");

        // Counter wrap
        cnt_r = 38'h3F_FFFF_FFF6;
        step(1, 1, 0, 0, 0);
        cnt_r = 38'd5;
        step(0, 0, 1, 1, 0);
        idle(5);
        check("wrap_lat", 64'(a_lat_data), 64'd15);
        check_state("wrap");

        // Orphan completion, then duplicate stamp
        step(0, 0, 1, 3, 0);
        idle(5);
        check("orphan_flag", 64'(a_err_orphan), 64'd1);
        check_state("orphan");
        cnt_r = 38'd1000;
        step(1, 7, 0, 0, 0);
        cnt_r = 38'd1100;
        step(1, 7, 0, 0, 0);
        cnt_r = 38'd1150;
        step(0, 0, 1, 7, 0);
        idle(5);
        check("dup_lat", 64'(a_lat_data), 64'd50);
        check("dup_flag", 64'(a_err_dup), 64'd1);
        check_state("dup");

        // Back-to-back 64 tags, latencies 10..73
        step(0, 0, 0, 0, 1);
        idle(2);
        for (int i = 0; i < 64; i++) begin
            cnt_r = 38'd5000 + CNT_W'(i);
            step(1, i, 0, 0, 0);
        end
        for (int i = 0; i < 64; i++) begin
            cnt_r = 38'd5000 + CNT_W'(i) + 38'd10 + CNT_W'(i);
            step(0, 0, 1, i, 0);
        end
        idle(5);
        check("b2b_min", 64'(a_lat_min), 64'd10);
        check("b2b_max", 64'(a_lat_max), 64'd73);
        check("b2b_sum", 64'(a_lat_sum), 64'd2656);
        check("b2b_num", 64'(a_lat_num), 64'd64);
        check("target_num", 64'(b_lat_num), 64'd4);
        check("target_done", 64'(b_done), 64'd1);
        check_state("b2b");

        // Clear one cycle after a completion
        cnt_r = 38'd200;
        step(1, 9, 0, 0, 0);
        cnt_r = 38'd260;
        step(0, 0, 1, 9, 0);
        step(0, 0, 0, 0, 1);
        idle(5);
        check("clr_lat_data", 64'(a_lat_data), 64'd0);
        check("clr_num", 64'(a_lat_num), 64'd0);
        check_state("clr");
        step(1, 2, 1, 2, 0);
        idle(3);
        check("same_cycle_outstanding", 64'(a_outstanding), 64'd1);
        check_state("same_cycle");

        // Randomised traffic over a small tag set to force collisions
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 15) == 0) cnt_r = cnt_r + CNT_W'($urandom_range(0, 5000));
            step($urandom_range(0, 1) == 1, int'($urandom_range(0, 7)),
                 $urandom_range(0, 1) == 1, int'($urandom_range(0, 7)),
                 $urandom_range(0, 99) == 0);
        end
        idle(6);
        check_state("random");
        check("queue_empty", 64'(exp_q.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
